// File: rtl/shift_tx_pkg.sv
// Shared definitions for the serial transmitter: FSM state encoding and a
// width helper used to size the bit counter.
package shift_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to count 0..value-1 (returns 0 for value <= 1).
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_tx_bit_timer.sv
// Loadable down-counter that sets the bit period; its terminal count marks the
// last cycle of each serial bit.
module bit_timer #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] load_val,
  output logic                 tc
);

  logic [DIV_WIDTH-1:0] tick_cnt;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // its inputs from before the edge; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (load) begin
      tick_cnt <= load_val;
    end else if (en) begin
      tick_cnt <= tick_cnt - 1'b1;
    end
  end

  assign tc = (tick_cnt == '0);

endmodule

// File: rtl/shift_tx.sv
// Parallel-in, serial-out transmitter: takes one word per valid/ready
// handshake and shifts it out MSB- or LSB-first with a per-bit strobe.
module shift_tx
  import shift_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  lsb_first,
  input  logic [DIV_WIDTH-1:0]  div,
  output logic                  sout,
  output logic                  sframe,
  output logic                  bit_strobe,
  output logic                  done
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic                  lsb_q;
  logic [DIV_WIDTH-1:0]  div_q;

  logic accept;
  logic tc;
  logic last_tick;
  logic last_bit;

  assign in_ready  = (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign last_tick = (state_q == SHIFT) && tc;
  assign last_bit  = (bit_cnt_q == LAST_BIT);

  // The timer reloads from the live div input on accept, and from the
  // captured copy between bits so mid-frame changes to div are ignored.
  bit_timer #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept || last_tick),
    .en       (state_q == SHIFT),
    .load_val (accept ? div : div_q),
    .tc       (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last_tick && last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      lsb_q     <= 1'b0;
      div_q     <= '0;
    end else if (accept) begin
      shift_q   <= in_data;
      bit_cnt_q <= '0;
      lsb_q     <= lsb_first;
      div_q     <= div;
    end else if (last_tick) begin
      // The final bit leaves the counter parked at zero instead of wrapping.
      bit_cnt_q <= last_bit ? '0 : bit_cnt_q + 1'b1;
      shift_q   <= lsb_q ? (shift_q >> 1) : (shift_q << 1);
    end
  end

  assign sframe     = (state_q == SHIFT);
  assign sout       = sframe && (lsb_q ? shift_q[0] : shift_q[DATA_WIDTH-1]);
  assign bit_strobe = last_tick;
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_shift_tx.sv
// Scoreboard bench for shift_tx: accepted words are queued with their timing
// parameters and every cycle of the resulting frame is compared to a model.
module tb_shift_tx;

  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          lsb_first;
  logic [7:0]    div;
  logic          sout;
  logic          sframe;
  logic          bit_strobe;
  logic          done;

  shift_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .lsb_first  (lsb_first),
    .div        (div),
    .sout       (sout),
    .sframe     (sframe),
    .bit_strobe (bit_strobe),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] word;
    logic          lsb;
    int            d;
    int            acc;
  } exp_t;

  exp_t sb[$];
  int   acc_log[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic [DW-1:0] rx = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Per-cycle model, sampled on the falling edge. Output vector order:
  // {in_ready, sframe, sout, bit_strobe, done}.
  exp_t mon_e;
  int   mon_off;
  int   mon_per;
  int   mon_idx;
  logic mon_bit;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      check("rst_outs", {in_ready, sframe, sout, bit_strobe, done}, 5'b10000);
    end else begin
      cyc++;
      if (sb.size() != 0) begin
        mon_e   = sb[0];
        mon_per = mon_e.d + 1;
        mon_off = cyc - mon_e.acc - 1;
        if (mon_off < DW * mon_per) begin
          mon_idx = mon_off / mon_per;
          mon_bit = mon_e.lsb ? mon_e.word[mon_idx] : mon_e.word[DW-1-mon_idx];
          check("frame_outs", {in_ready, sframe, sout, bit_strobe, done},
                {1'b0, 1'b1, mon_bit, (mon_off % mon_per) == mon_per - 1, 1'b0});
          if (bit_strobe)
            rx = mon_e.lsb ? {sout, rx[DW-1:1]} : {rx[DW-2:0], sout};
        end else begin
          check("done_outs", {in_ready, sframe, sout, bit_strobe, done}, 5'b00001);
          check("rx_word", rx, mon_e.word);
          void'(sb.pop_front());
        end
      end else begin
        check("idle_outs", {in_ready, sframe, sout, bit_strobe, done}, 5'b10000);
      end
      if (in_valid && in_ready) begin
        sb.push_back('{in_data, lsb_first, int'(div), cyc});
        acc_log.push_back(cyc);
        rx = '0;
      end
    end
  end

  task automatic send(input logic [DW-1:0] w, input logic lsb, input logic [7:0] d,
                      input bit keep);
    int n;
    n = 0;
    in_valid  = 1'b1;
    in_data   = w;
    lsb_first = lsb;
    div       = d;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 600);
    if (!in_ready) check("accept_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    check("done_seen", done, 1'b1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    lsb_first = 1'b0;
    div       = '0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset during bit 5 of an MSB-first, div=2 frame.
    send(16'hA5C3, 1'b0, 8'd2, 1'b0);
    repeat (16) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_outs", {in_ready, sframe, sout, bit_strobe, done}, 5'b10000);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_no_frame", sb.size(), 0);
    @(posedge clk);
    #1;
    send(16'hA5C3, 1'b0, 8'd2, 1'b0);
    wait_done(100);

    // MSB-first, one cycle per bit.
    @(posedge clk);
    #1;
    send(16'hA5C3, 1'b0, 8'd0, 1'b0);
    wait_done(40);

    // LSB-first, four cycles per bit.
    @(posedge clk);
    #1;
    send(16'h0001, 1'b1, 8'd3, 1'b0);
    wait_done(100);

    // Inputs changed mid-frame must be ignored.
    @(posedge clk);
    #1;
    send(16'h3C96, 1'b0, 8'd1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_data   = 16'hFFFF;
    div       = 8'd5;
    lsb_first = 1'b1;
    #1 check("busy_ready", in_ready, 1'b0);
    wait_done(100);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("no_second_frame", sb.size(), 0);

    // Back-to-back words with in_valid held high.
    acc_log.delete();
    @(posedge clk);
    #1;
    send(16'h1234, 1'b0, 8'd1, 1'b1);
    send(16'h5678, 1'b0, 8'd1, 1'b0);
    wait_done(100);
    repeat (3) @(negedge clk);
    check("b2b_accepts", acc_log.size(), 2);
    if (acc_log.size() == 2) check("b2b_spacing", acc_log[1] - acc_log[0], 34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/shift_tx.md
# shift_tx

Parallel-in, serial-out transmitter for the datapath. Accepts one DATA_WIDTH-bit word per valid/ready handshake and drives it out one bit at a time, MSB-first or LSB-first, at a programmable bit period. It provides a per-bit strobe, so a downstream shift register can capture each bit through its serial-in and shift-enable pins. It is the sending end of the serial links between datapath registers and off-block peers.

## Interface
Parameters:
- DATA_WIDTH, 16, word width in bits.
- DIV_WIDTH, 8, width of the bit-period divider.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  word on in_data is offered.
- in_ready  output  1  block can accept a word; equals (state == IDLE).
- in_data  input  DATA_WIDTH  word to transmit.
- lsb_first  input  1  order select; 1 = bit 0 first, 0 = bit DATA_WIDTH-1 first.
- div  input  DIV_WIDTH  cycles per bit minus 1.
- sout  output  1  serial data; registered; 0 when no frame is active.
- sframe  output  1  high for the whole time bits are on sout.
- bit_strobe  output  1  one-cycle pulse in the last cycle of each bit.
- done  output  1  one-cycle pulse after the last bit.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1; sout=0, sframe=0, bit_strobe=0, done=0.
  - When in_valid && in_ready at an edge: capture in_data into the shift register, capture lsb_first and div, load bit_cnt=0 and tick_cnt=div, go to SHIFT.
- SHIFT:
  - sframe=1.
  - sout = shift[DATA_WIDTH-1] if MSB-first, else shift[0].
  - tick_cnt decrements each cycle.
  - When tick_cnt==0:
    - bit_strobe=1 that cycle.
    - Next edge: shift by one position (left for MSB-first, right for LSB-first, 0 filled), bit_cnt+1, tick_cnt reloads the captured div.
    - If bit_cnt==DATA_WIDTH-1, go to DONE instead.
- DONE:
  - done=1 and sframe=0 for exactly one cycle; sout=0; in_ready=0.
  - Next state is IDLE.
- Captured values hold for the whole frame. Changes on in_data, lsb_first or div mid-frame have no effect.
- in_valid outside IDLE is ignored; no word is queued.
- div=0 gives one cycle per bit, with bit_strobe high on every SHIFT cycle.
- bit_cnt width is clog2(DATA_WIDTH). No wrap-around of bit_cnt is reachable.

## Timing
- Reset (asynchronous, any state):
  - state=IDLE, shift=0, bit_cnt=0, tick_cnt=0.
  - sout=0, sframe=0, bit_strobe=0, done=0, in_ready=1, including while rst_n is low.
- Reset mid-frame aborts the frame immediately. No done pulse is issued.
- Handshake accepted at edge k:
  - sframe rises and the first bit appears on sout in cycle k+1.
  - Each bit lasts div+1 cycles.
  - sframe is high for DATA_WIDTH*(div+1) cycles.
  - done is high in the following cycle.
  - in_ready returns in the cycle after done.
- Back-to-back words: minimum spacing between accepts is DATA_WIDTH*(div+1)+2 cycles.
- Outputs sout, sframe, bit_strobe and done are registered or decoded from registered state only. There is no combinational path from any input to them.
- in_ready is a decode of state only.

## Structure
- Shared package shift_tx_pkg holds:
  - the state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - a clog2 helper for bit_cnt width.
- One sub-module, bit_timer:
  - loadable down-counter of DIV_WIDTH bits with load value, load enable and a terminal-count output (tick_cnt==0);
  - drives bit_strobe generation.
- Shift register, bit counter and FSM live in shift_tx.

## Test plan
- Reset mid-frame: accept 16'hA5C3 MSB-first with div=2, assert rst_n=0 during bit 5 -> all outputs take reset values at once, no done pulse, in_ready=1; next word transmits correctly.
- MSB-first, div=0: accept 16'hA5C3 -> sout at each bit_strobe is 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; sframe high 16 cycles; done in cycle 17 after accept.
- LSB-first, div=3: accept 16'h0001 -> sout=1 for the first 4 cycles, then 0 for 60 cycles; 16 bit_strobe pulses 4 cycles apart; done 65 cycles after accept.
- Ignored inputs: during SHIFT, drive in_valid=1 with 16'hFFFF and change div and lsb_first -> in_ready=0, the transmitted word and timing are unchanged, no second frame starts.
- Back-to-back: in_valid held high with 16'h1234 then 16'h5678, div=1 -> accepts exactly 34 cycles apart; both frames decode correctly in a loopback into a shift register fed by sout and enabled by bit_strobe.
